time_display_scanner: RTL and testbench

- Downstream consumer of the normal-clock time counter.
- Takes binary hours/minutes/seconds plus the PM flag and drives a 6-digit multiplexed common-anode 7-segment display showing HH MM SS.
- Per digit: binary-to-BCD split, glyph decode, time-multiplexed digit scan.
- Captures one coherent time snapshot per scan frame, so the display never tears mid-frame.

---
 rtl/time_display_scanner.sv | 139 +++++++++++++
 tb/tb_time_display_scanner.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/time_display_scanner.sv
// 6-digit multiplexed common-anode 7-segment scanner for HH MM SS with per-frame time snapshot.
// Optional: define HOUR_LEADING_BLANK_EN to blank the hours-tens digit when hours < 10.
`timescale 1ns/1ps

module time_display_bcd_split (
  input  logic [5:0] bin,
  output logic [2:0] tens,
  output logic [3:0] ones
);
  logic found;

  // Highest multiple of ten not above bin wins; below 10 the value passes straight through.
  always_comb begin
    tens  = '0;
    ones  = bin[3:0];
    found = 1'b0;
    for (int k = 6; k >= 1; k--) begin
      if (!found && bin >= 6'(10 * k)) begin
        found = 1'b1;
        tens  = 3'(k);
        ones  = 4'(bin - 6'(10 * k));
      end
    end
  end
endmodule

module time_display_scanner #(
  parameter int SCAN_DIV = 50000,
  parameter int CNT_W    = $clog2(SCAN_DIV)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] hours,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic       isPM,
  output logic [5:0] anode,
  output logic [7:0] segments
);
  localparam int NUM_FIELDS = 3;  // 0 = hours, 1 = minutes, 2 = seconds

  logic [CNT_W-1:0]                dwell_cnt, dwell_nxt;
  logic [2:0]                      digit_idx, idx_nxt;
  logic [NUM_FIELDS-1:0][5:0]      snap, snap_nxt;
  logic                            snap_pm, pm_nxt;
  logic                            prime;
  logic [NUM_FIELDS-1:0][2:0]      tens;
  logic [NUM_FIELDS-1:0][3:0]      ones;
  logic                            dwell_end, frame_wrap, load;
  logic [3:0]                      digit;
  logic [5:0]                      anode_nxt;
  logic [7:0]                      seg_nxt;

  function automatic logic [7:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 8'hC0;
      4'd1:    glyph = 8'hF9;
      4'd2:    glyph = 8'hA4;
      4'd3:    glyph = 8'hB0;
      4'd4:    glyph = 8'h99;
      4'd5:    glyph = 8'h92;
      4'd6:    glyph = 8'h82;
      4'd7:    glyph = 8'hF8;
      4'd8:    glyph = 8'h80;
      4'd9:    glyph = 8'h90;
      default: glyph = 8'hFF;
    endcase
  endfunction

  generate
    for (genvar f = 0; f < NUM_FIELDS; f++) begin : g_bcd
      time_display_bcd_split u_bcd (
        .bin  (snap[f]),
        .tens (tens[f]),
        .ones (ones[f])
      );
    end
  endgenerate

  assign dwell_end  = (dwell_cnt == CNT_W'(SCAN_DIV - 1));
  assign frame_wrap = dwell_end && (digit_idx == 3'd5);
  // The first post-reset edge also loads so the display does not wait a whole frame for real time.
  assign load       = prime || frame_wrap;

  always_comb begin
    dwell_nxt = dwell_end ? '0 : dwell_cnt + CNT_W'(1);
    idx_nxt   = digit_idx;
    if (dwell_end) idx_nxt = (digit_idx == 3'd5) ? 3'd0 : digit_idx + 3'd1;
    snap_nxt  = snap;
    pm_nxt    = snap_pm;
    if (load) begin
      snap_nxt[0] = {1'b0, hours};
      snap_nxt[1] = minutes;
      snap_nxt[2] = seconds;
      pm_nxt      = isPM;
    end
  end

  always_comb begin
    digit = '0;
    case (digit_idx)
      3'd0:    digit = {1'b0, tens[0]};
      3'd1:    digit = ones[0];
      3'd2:    digit = {1'b0, tens[1]};
      3'd3:    digit = ones[1];
      3'd4:    digit = {1'b0, tens[2]};
      3'd5:    digit = ones[2];
      default: digit = '0;
    endcase
    anode_nxt = ~(6'b100000 >> digit_idx);
    seg_nxt   = glyph(digit);
    if (digit_idx == 3'd1 && snap_pm) seg_nxt[7] = 1'b0;
`ifdef HOUR_LEADING_BLANK_EN
    // Anode still fires so every digit keeps the same duty cycle.
    if (digit_idx == 3'd0 && snap[0] < 6'd10) seg_nxt = 8'hFF;
`else
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dwell_cnt <= '0;
      digit_idx <= '0;
      snap      <= '0;
      snap_pm   <= 1'b0;
      prime     <= 1'b1;
      anode     <= 6'b111111;
      segments  <= 8'hFF;
    end else begin
      dwell_cnt <= dwell_nxt;
      digit_idx <= idx_nxt;
      snap      <= snap_nxt;
      snap_pm   <= pm_nxt;
      prime     <= 1'b0;
      anode     <= anode_nxt;
      segments  <= seg_nxt;
    end
  end
endmodule

// File: tb/tb_time_display_scanner.sv
// Scoreboard bench: two scanners (dwell 4 and 2) against an arithmetic model of the scan schedule.
`timescale 1ns/1ps

module tb_time_display_scanner;
  typedef struct packed {
    logic [5:0] an;
    logic [7:0] seg;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] hours;
  logic [5:0] minutes, seconds;
  logic       isPM;
  logic [5:0] anode4, anode2;
  logic [7:0] seg4, seg2;

  int checks = 0;
  int errors = 0;

  exp_t q0[$];
  exp_t q1[$];

  int   divs[2] = '{4, 2};
  int   mt[2];
  int   mh[2], mm[2], ms[2];
  bit   mpm[2], mprime[2];
  logic [7:0] gly[10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  always #5 clk = ~clk;

  time_display_scanner #(.SCAN_DIV(4)) dut4 (
    .clk(clk), .reset(reset), .hours(hours), .minutes(minutes), .seconds(seconds),
    .isPM(isPM), .anode(anode4), .segments(seg4)
  );

  time_display_scanner #(.SCAN_DIV(2)) dut2 (
    .clk(clk), .reset(reset), .hours(hours), .minutes(minutes), .seconds(seconds),
    .isPM(isPM), .anode(anode2), .segments(seg2)
  );

  // Model: after t non-reset edges the shown digit is (t/D)%6; the time shown is whatever
  // was captured on the first edge or on the last edge of the previous frame.
  task automatic model_edge(input int u);
    exp_t e;
    int   idx, d, per;
    if (reset) begin
      e.an = 6'h3F; e.seg = 8'hFF;
      mt[u] = 0; mh[u] = 0; mm[u] = 0; ms[u] = 0; mpm[u] = 1'b0; mprime[u] = 1'b1;
    end else begin
      per = 6 * divs[u];
      idx = (mt[u] / divs[u]) % 6;
      case (idx)
        0:       d = mh[u] / 10;
        1:       d = mh[u] % 10;
        2:       d = mm[u] / 10;
        3:       d = mm[u] % 10;
        4:       d = ms[u] / 10;
        default: d = ms[u] % 10;
      endcase
      e.an  = 6'h3F & ~(6'd1 << (5 - idx));
      e.seg = gly[d];
      if (idx == 1 && mpm[u]) e.seg[7] = 1'b0;
`ifdef HOUR_LEADING_BLANK_EN
      if (idx == 0 && mh[u] < 10) e.seg = 8'hFF;
`else
`endif
      if (mprime[u] || (mt[u] % per) == per - 1) begin
        mh[u] = int'(hours); mm[u] = int'(minutes); ms[u] = int'(seconds); mpm[u] = isPM;
      end
      mprime[u] = 1'b0;
      mt[u]++;
    end
    if (u == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic step(input bit r, input int h, input int m, input int s, input bit pm);
    reset   = r;
    hours   = 5'(h);
    minutes = 6'(m);
    seconds = 6'(s);
    isPM    = pm;
    model_edge(0);
    model_edge(1);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("div4_anode", {2'b00, anode4}, {2'b00, e.an});
        chk("div4_segments", seg4, e.seg);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("div2_anode", {2'b00, anode2}, {2'b00, e.an});
        chk("div2_segments", seg2, e.seg);
      end
    end
  end

  initial begin
    // Reset, then 12:34:56 AM; reset again while the div-4 scanner sits on digit 3.
    step(1, 12, 34, 56, 0);
    step(1, 12, 34, 56, 0);
    for (int i = 0; i < 14; i++) step(0, 12, 34, 56, 0);
    step(1, 12, 34, 56, 0);
    // 7:00:09 PM: dp on hours-ones digit, hours tens 0 or blank.
    for (int i = 0; i < 48; i++) step(0, 7, 0, 9, 1);
    // Out-of-calendar values shown literally.
    step(1, 31, 63, 0, 0);
    for (int i = 0; i < 30; i++) step(0, 31, 63, 0, 0);
    // Seconds change mid-frame must not tear the frame.
    step(1, 12, 34, 56, 0);
    for (int i = 0; i < 72; i++) step(0, 12, 34, (i >= 34) ? 57 : 56, 0);
    // Inputs changing every cycle with occasional resets.
    for (int i = 0; i < 700; i++)
      step($urandom_range(99) == 0, int'($urandom_range(31)), int'($urandom_range(63)),
           int'($urandom_range(63)), $urandom_range(1) == 1);
    @(posedge clk);
    #3;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d/%0d pending expected=0", q0.size(), q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
